mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory (BRAM, fixed read latency) between instruction fetch (F) and data load/store (D) requesters of the RISC-V core.
- Data has priority by default, so an in-flight load is never blocked by fetch; a starvation guard forces periodic fetch grants.
- In-order response routing via a latency-matched tag pipeline; supports fetch squash on branch/jump redirect.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if.sv
// Request/response and memory bus shared by the fetch and data requesters,
// the arbiter and the single-ported synchronous memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic                  f_req_valid;
  logic [ADDR_W-1:0]     f_req_addr;
  logic                  f_req_ready;
  logic                  f_rsp_valid;
  logic [DATA_W-1:0]     f_rsp_data;

  logic                  d_req_valid;
  logic                  d_req_we;
  logic [ADDR_W-1:0]     d_req_addr;
  logic [DATA_W/8-1:0]   d_req_wmask;
  logic [DATA_W-1:0]     d_req_wdata;
  logic                  d_req_ready;
  logic                  d_rsp_valid;
  logic [DATA_W-1:0]     d_rsp_data;

  logic                  flush;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Requester and memory side: drives requests, flush and read data.
  modport master (
    output f_req_valid, f_req_addr, d_req_valid, d_req_we, d_req_addr,
           d_req_wmask, d_req_wdata, flush, mem_rdata,
    input  f_req_ready, f_rsp_valid, f_rsp_data, d_req_ready, d_rsp_valid,
           d_rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  f_req_valid, f_req_addr, d_req_valid, d_req_we, d_req_addr,
           d_req_wmask, d_req_wdata, flush, mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, d_req_ready, d_rsp_valid,
           d_rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch (F)
// and data load/store (D). Data wins by default; a starvation counter forces
// a fetch grant after MAX_STARVE stalled cycles. Read responses are routed
// back in order through a tag pipeline matched to MEM_LAT, and flush squashes
// fetch tags still in flight.
// Optional macro ARB_STATS_EN builds saturating grant/conflict counters;
// without it the stat ports are tied to zero.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [31:0]       stat_f_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  typedef enum logic {
    D_PRIO = 1'b0,
    F_PRIO = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_starveCnt;
  logic [MEM_LAT-1:0]  r_tagValid;
  logic [MEM_LAT-1:0]  r_tagIsF;

  logic                w_fGrant;
  logic                w_dGrant;
  logic                w_newTag;
  logic                w_exitValid;
  logic                w_exitIsF;
  logic                w_fRsp;
  logic                w_dRsp;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W/8-1:0] w_we;
  logic [DATA_W-1:0]   w_wdata;

  // Pick at most one winner per cycle; nothing is granted while reset is held.
  always_comb begin
    w_fGrant = 1'b0;
    w_dGrant = 1'b0;
    if (!rst) begin
      if (r_state == F_PRIO) begin
        w_fGrant = bus.f_req_valid;
        w_dGrant = bus.d_req_valid && !bus.f_req_valid;
      end else begin
        w_dGrant = bus.d_req_valid;
        w_fGrant = bus.f_req_valid && !bus.d_req_valid;
      end
    end
  end

  assign bus.f_req_ready = w_fGrant;
  assign bus.d_req_ready = w_dGrant;

  // Steer the granted request onto the memory port; idle port drives zeros.
  always_comb begin
    w_addr  = '0;
    w_we    = '0;
    w_wdata = '0;
    if (w_dGrant) begin
      w_addr = bus.d_req_addr;
      if (bus.d_req_we) begin
        w_we    = bus.d_req_wmask;
        w_wdata = bus.d_req_wdata;
      end
    end else if (w_fGrant) begin
      w_addr = bus.f_req_addr;
    end
  end

  assign bus.mem_en    = w_fGrant || w_dGrant;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  // Priority FSM and starvation counter: a fetch that keeps losing gets one forced grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= D_PRIO;
      r_starveCnt <= '0;
    end else begin
      case (r_state)
        D_PRIO: if (r_starveCnt == CNT_W'(MAX_STARVE) && !w_fGrant) r_state <= F_PRIO;
        F_PRIO: if (w_fGrant) r_state <= D_PRIO;
      endcase
      if (!bus.f_req_valid || w_fGrant) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != CNT_W'(MAX_STARVE)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
    end
  end

  // Stores need no response, and a fetch accepted under flush is already dead.
  assign w_newTag = (w_dGrant && !bus.d_req_we) || (w_fGrant && !bus.flush);

  // Owner tags march alongside the memory read latency; flush kills fetch tags in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagValid <= '0;
      r_tagIsF   <= '0;
    end else begin
      r_tagValid[0] <= w_newTag;
      r_tagIsF[0]   <= w_fGrant;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1] && !(bus.flush && r_tagIsF[i-1]);
        r_tagIsF[i]   <= r_tagIsF[i-1];
      end
    end
  end

  assign w_exitValid = r_tagValid[MEM_LAT-1];
  assign w_exitIsF   = r_tagIsF[MEM_LAT-1];
  assign w_fRsp      = w_exitValid && w_exitIsF;
  assign w_dRsp      = w_exitValid && !w_exitIsF;

  assign bus.f_rsp_valid = w_fRsp;
  assign bus.d_rsp_valid = w_dRsp;
  assign bus.f_rsp_data  = w_fRsp ? bus.mem_rdata : '0;
  assign bus.d_rsp_data  = w_dRsp ? bus.mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic [31:0] r_statF;
  logic [31:0] r_statD;
  logic [31:0] r_statC;

  // Saturating usage counters for grants and for cycles where both sides competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statF <= '0;
      r_statD <= '0;
      r_statC <= '0;
    end else begin
      if (w_fGrant && r_statF != 32'hFFFF_FFFF) r_statF <= r_statF + 32'd1;
      if (w_dGrant && r_statD != 32'hFFFF_FFFF) r_statD <= r_statD + 32'd1;
      if (bus.f_req_valid && bus.d_req_valid && r_statC != 32'hFFFF_FFFF) r_statC <= r_statC + 32'd1;
    end
  end

  assign stat_f_grants  = r_statF;
  assign stat_d_grants  = r_statD;
  assign stat_conflicts = r_statC;
`else
  assign stat_f_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table, a
// reset-with-loads-in-flight sequence and a randomized run, all compared
// against a cycle-scheduled reference model. Stat checks follow ARB_STATS_EN.
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 32;
  localparam int MEM_LAT     = 2;
  localparam int MAX_STARVE  = 4;
  localparam int RAND_CYCLES = 1500;
  localparam int OWN_NONE    = 0;
  localparam int OWN_F       = 1;
  localparam int OWN_D       = 2;

  typedef struct {
    bit                fv;
    logic [ADDR_W-1:0] fa;
    bit                dv;
    bit                dwe;
    logic [ADDR_W-1:0] da;
    logic [3:0]        dm;
    logic [31:0]       dwd;
    bit                fl;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          eFr;
    bit          eDr;
    logic [3:0]  eWe;
    bit          eFv;
    logic [31:0] eFd;
    bit          eDv;
    logic [31:0] eDd;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        memLoad;
  logic [31:0] statF;
  logic [31:0] statD;
  logic [31:0] statC;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stat_f_grants(statF),
    .stat_d_grants(statD),
    .stat_conflicts(statC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Memory device: byte-masked writes, reads delivered MEM_LAT cycles after the access.
  logic [31:0] tbMem [64];
  logic [31:0] rdPipe [MEM_LAT];

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 64; i++) tbMem[i] <= 32'(i + 100);
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) tbMem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    rdPipe[0] <= tbMem[bus.mem_addr[5:0]];
    for (int i = 1; i < MEM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign bus.mem_rdata = rdPipe[MEM_LAT-1];

  // Reference model: responses are booked into the cycle they must appear in.
  stim_t       cur;
  bit          mPrioF;
  int          mStarve;
  int          mNow;
  int          schedOwner [64];
  logic [31:0] schedData [64];
  logic [31:0] refMem [64];
  int          mStatF;
  int          mStatD;
  int          mStatC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (model cycle %0d, t=%0t)", name, act, exp, mNow, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.fv = 1'b0; s.fa = '0; s.dv = 1'b0; s.dwe = 1'b0;
    s.da = '0; s.dm = '0; s.dwd = '0; s.fl = 1'b0;
    return s;
  endfunction

  function automatic vec_t mkVec(int fv, int fa, int dv, int dwe, int da, int dm, int dwd, int fl,
                                 int eFr, int eDr, int eWe, int eFv, int eFd, int eDv, int eDd);
    vec_t v;
    v.s.fv = (fv != 0); v.s.fa = ADDR_W'(fa); v.s.dv = (dv != 0); v.s.dwe = (dwe != 0);
    v.s.da = ADDR_W'(da); v.s.dm = 4'(dm); v.s.dwd = 32'(dwd); v.s.fl = (fl != 0);
    v.eFr = (eFr != 0); v.eDr = (eDr != 0); v.eWe = 4'(eWe);
    v.eFv = (eFv != 0); v.eFd = 32'(eFd); v.eDv = (eDv != 0); v.eDd = 32'(eDd);
    return v;
  endfunction

  function automatic stim_t randStim(int dvPct);
    stim_t s;
    s.fv  = ($urandom_range(0, 99) < 60);
    s.fa  = ADDR_W'($urandom_range(0, 63));
    s.dv  = ($urandom_range(0, 99) < dvPct);
    s.dwe = ($urandom_range(0, 99) < 30);
    s.da  = ADDR_W'($urandom_range(0, 63));
    s.dm  = 4'($urandom_range(0, 15));
    s.dwd = $urandom();
    s.fl  = ($urandom_range(0, 99) < 8);
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    cur = s;
    bus.f_req_valid = s.fv;
    bus.f_req_addr  = s.fa;
    bus.d_req_valid = s.dv;
    bus.d_req_we    = s.dwe;
    bus.d_req_addr  = s.da;
    bus.d_req_wmask = s.dm;
    bus.d_req_wdata = s.dwd;
    bus.flush       = s.fl;
  endtask

  task automatic modelReset();
    mPrioF = 1'b0;
    mStarve = 0;
    for (int i = 0; i < 64; i++) begin
      schedOwner[i] = OWN_NONE;
      schedData[i] = '0;
    end
    mStatF = 0; mStatD = 0; mStatC = 0;
  endtask

  task automatic resetCheck(input string tag);
    check({tag, " f_req_ready"}, 32'(bus.f_req_ready), 32'd0);
    check({tag, " d_req_ready"}, 32'(bus.d_req_ready), 32'd0);
    check({tag, " f_rsp_valid"}, 32'(bus.f_rsp_valid), 32'd0);
    check({tag, " f_rsp_data"}, bus.f_rsp_data, 32'd0);
    check({tag, " d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'd0);
    check({tag, " d_rsp_data"}, bus.d_rsp_data, 32'd0);
    check({tag, " mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, " stat_f_grants"}, statF, 32'd0);
    check({tag, " stat_d_grants"}, statD, 32'd0);
    check({tag, " stat_conflicts"}, statC, 32'd0);
  endtask

  // Compare one cycle at the falling edge, advance the model, then step past the rising edge.
  task automatic checkOutput(input bit useVec, input vec_t v);
    bit dWin, fWin;
    int slot, owner, a, k;
    logic [31:0] expWe;
    @(negedge clk);
    dWin  = cur.dv && (!mPrioF || !cur.fv);
    fWin  = cur.fv && !dWin;
    slot  = mNow % 64;
    owner = schedOwner[slot];
    expWe = (dWin && cur.dwe) ? 32'(cur.dm) : 32'd0;

    check("f_req_ready", 32'(bus.f_req_ready), 32'(fWin));
    check("d_req_ready", 32'(bus.d_req_ready), 32'(dWin));
    check("mem_en", 32'(bus.mem_en), 32'(fWin || dWin));
    check("mem_we", 32'(bus.mem_we), expWe);
    if (dWin) check("mem_addr d", 32'(bus.mem_addr), 32'(cur.da));
    else if (fWin) check("mem_addr f", 32'(bus.mem_addr), 32'(cur.fa));
    if (dWin && cur.dwe) check("mem_wdata", bus.mem_wdata, cur.dwd);
    check("f_rsp_valid", 32'(bus.f_rsp_valid), 32'(owner == OWN_F));
    check("f_rsp_data", bus.f_rsp_data, (owner == OWN_F) ? schedData[slot] : 32'd0);
    check("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(owner == OWN_D));
    check("d_rsp_data", bus.d_rsp_data, (owner == OWN_D) ? schedData[slot] : 32'd0);
`ifdef ARB_STATS_EN
    check("stat_f_grants", statF, 32'(mStatF));
    check("stat_d_grants", statD, 32'(mStatD));
    check("stat_conflicts", statC, 32'(mStatC));
`else
    check("stat_f_grants", statF, 32'd0);
    check("stat_d_grants", statD, 32'd0);
    check("stat_conflicts", statC, 32'd0);
`endif
    if (useVec) begin
      check("tbl f_req_ready", 32'(bus.f_req_ready), 32'(v.eFr));
      check("tbl d_req_ready", 32'(bus.d_req_ready), 32'(v.eDr));
      check("tbl mem_we", 32'(bus.mem_we), 32'(v.eWe));
      check("tbl f_rsp_valid", 32'(bus.f_rsp_valid), 32'(v.eFv));
      check("tbl f_rsp_data", bus.f_rsp_data, v.eFd);
      check("tbl d_rsp_valid", 32'(bus.d_rsp_valid), 32'(v.eDv));
      check("tbl d_rsp_data", bus.d_rsp_data, v.eDd);
    end

    schedOwner[slot] = OWN_NONE;
    if (cur.fl) begin
      for (k = 1; k < MEM_LAT; k++)
        if (schedOwner[(mNow + k) % 64] == OWN_F) schedOwner[(mNow + k) % 64] = OWN_NONE;
    end
    if (dWin) begin
      a = int'(cur.da[5:0]);
      if (cur.dwe) begin
        for (int b = 0; b < 4; b++)
          if (cur.dm[b]) refMem[a][8*b +: 8] = cur.dwd[8*b +: 8];
      end else begin
        schedOwner[(mNow + MEM_LAT) % 64] = OWN_D;
        schedData[(mNow + MEM_LAT) % 64]  = refMem[a];
      end
    end
    if (fWin && !cur.fl) begin
      schedOwner[(mNow + MEM_LAT) % 64] = OWN_F;
      schedData[(mNow + MEM_LAT) % 64]  = refMem[int'(cur.fa[5:0])];
    end
    if (fWin) mStatF++;
    if (dWin) mStatD++;
    if (cur.fv && cur.dv) mStatC++;
    if (mPrioF) begin
      if (fWin) mPrioF = 1'b0;
    end else if (mStarve == MAX_STARVE && !fWin) begin
      mPrioF = 1'b1;
    end
    if (!cur.fv || fWin) mStarve = 0;
    else if (mStarve < MAX_STARVE) mStarve++;
    mNow++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs[$];
    vec_t  dummy;
    stim_t s;

    dummy = mkVec(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    applyStimulus(idleStim());
    rst = 1'b1;
    memLoad = 1'b1;
    for (int i = 0; i < 64; i++) refMem[i] = 32'(i + 100);
    mNow = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetCheck("reset");
    rst = 1'b0;
    memLoad = 1'b0;
    @(posedge clk);
    #1;

    // fv fa dv dwe da dm dwd fl | Fr Dr We Fv Fd Dv Dd   (MEM_LAT=2, MAX_STARVE=4)
    vecs.push_back(mkVec(1,0, 0,0,0,0,0,0,  1,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(1,1, 0,0,0,0,0,0,  1,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(1,2, 0,0,0,0,0,0,  1,0,0, 1,100, 0,0));
    vecs.push_back(mkVec(1,9, 1,0,5,0,0,0,  0,1,0, 1,101, 0,0));
    vecs.push_back(mkVec(1,9, 0,0,0,0,0,0,  1,0,0, 1,102, 0,0));
    vecs.push_back(mkVec(0,0, 1,1,7,3,32'hAABBCCDD,0, 0,1,3, 0,0, 1,105));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 1,109, 0,0));
    vecs.push_back(mkVec(0,0, 1,0,7,0,0,0,  0,1,0, 0,0,   0,0));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   1,32'h0000CCDD));
    vecs.push_back(mkVec(1,20, 1,0,10,0,0,0, 0,1,0, 0,0,  0,0));
    vecs.push_back(mkVec(1,20, 1,0,11,0,0,0, 0,1,0, 0,0,  0,0));
    vecs.push_back(mkVec(1,20, 1,0,12,0,0,0, 0,1,0, 0,0,  1,110));
    vecs.push_back(mkVec(1,20, 1,0,13,0,0,0, 0,1,0, 0,0,  1,111));
    vecs.push_back(mkVec(1,20, 1,0,14,0,0,0, 0,1,0, 0,0,  1,112));
    vecs.push_back(mkVec(1,20, 1,0,15,0,0,0, 1,0,0, 0,0,  1,113));
    vecs.push_back(mkVec(1,20, 1,0,16,0,0,0, 0,1,0, 0,0,  1,114));
    vecs.push_back(mkVec(1,20, 1,0,17,0,0,0, 0,1,0, 1,120, 0,0));
    vecs.push_back(mkVec(1,20, 1,0,18,0,0,0, 0,1,0, 0,0,  1,116));
    vecs.push_back(mkVec(1,20, 1,0,19,0,0,0, 0,1,0, 0,0,  1,117));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   1,118));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   1,119));
    vecs.push_back(mkVec(1,30, 0,0,0,0,0,0, 1,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(1,31, 0,0,0,0,0,1, 1,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(1,32, 0,0,0,0,0,0, 1,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   0,0));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 1,132, 0,0));
    vecs.push_back(mkVec(0,0, 0,0,0,0,0,0,  0,0,0, 0,0,   0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      checkOutput(1'b1, vecs[i]);
    end

    // Two loads in flight, then an asynchronous reset with both requesters active.
    s = idleStim();
    s.dv = 1'b1; s.da = ADDR_W'(3);
    applyStimulus(s);
    checkOutput(1'b0, dummy);
    s.da = ADDR_W'(4);
    applyStimulus(s);
    checkOutput(1'b0, dummy);
    s.fv = 1'b1; s.fa = ADDR_W'(8); s.da = ADDR_W'(6);
    applyStimulus(s);
    rst = 1'b1;
    #1;
    resetCheck("midrst");
    @(negedge clk);
    resetCheck("midrst held");
    applyStimulus(idleStim());
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    for (int i = 0; i < MEM_LAT + 3; i++) begin
      applyStimulus(idleStim());
      checkOutput(1'b0, dummy);
    end

    for (int i = 0; i < RAND_CYCLES; i++) begin
      applyStimulus(randStim(((i / 200) % 2 == 1) ? 85 : 50));
      checkOutput(1'b0, dummy);
    end

    applyStimulus(idleStim());
    for (int i = 0; i < MEM_LAT + 1; i++) checkOutput(1'b0, dummy);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
